// File: rtl/asfifo_rd_drain.sv
// Read-domain drain engine: pops the asfifo read port into a 3-entry buffer and re-presents words
// on a valid/ready stream. Optional sequence checker enabled by `define ASFIFO_RD_SEQ_CHECK_EN.
module asfifo_rd_drain #(
   parameter int WIDTH = 16
) (
   input  logic             rd_clk,
   input  logic             rd_rst_n,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rd_data,
   input  logic             fifo_rd_empty,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             seq_err,
   output logic [7:0]       seq_err_cnt
);

   logic [1:0]       r_occ;
   logic             r_inflight;
   logic [1:0]       r_wptr;
   logic [1:0]       r_rptr;
   logic [WIDTH-1:0] r_buf [3];

   logic             w_credit;
   logic             w_pop;
   logic [WIDTH-1:0] w_head;

   function automatic logic [1:0] f_next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // A word already in flight owns a slot, so credit counts it alongside the occupancy.
   assign w_credit   = ({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3;
   assign fifo_rd_en = rd_rst_n && !fifo_rd_empty && w_credit;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      w_head = r_buf[0];
      case (r_rptr)
         2'd1:    w_head = r_buf[1];
         2'd2:    w_head = r_buf[2];
         default: w_head = r_buf[0];
      endcase
   end

   assign m_valid = (r_occ != 2'd0);
   assign m_data  = w_head;
   assign w_pop   = m_valid && m_ready;

   // NOTE: sequential state uses non-blocking assignments only; the buffer is reset too,
   // because m_data must read as zero out of reset rather than stale storage.
   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_wptr     <= 2'd0;
         r_rptr     <= 2'd0;
         for (int i = 0; i < 3; i++) r_buf[i] <= '0;
      end else begin
         r_inflight <= fifo_rd_en;
         if (r_inflight) begin
            for (int i = 0; i < 3; i++) begin
               if (r_wptr == 2'(i)) r_buf[i] <= fifo_rd_data;
            end
            r_wptr <= f_next_ptr(r_wptr);
         end
         if (w_pop) r_rptr <= f_next_ptr(r_rptr);
         r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

`ifdef ASFIFO_RD_SEQ_CHECK_EN
   logic             r_have_prev;
   logic [WIDTH-1:0] r_prev;
   logic             r_seq_err;
   logic [7:0]       r_seq_err_cnt;
   logic [WIDTH-1:0] w_expect;
   logic             w_mismatch;

   // The first word after reset only seeds the expectation; later words must follow it by +1.
   assign w_expect   = r_prev + WIDTH'(1);
   assign w_mismatch = w_pop && r_have_prev && (m_data != w_expect);

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         r_have_prev   <= 1'b0;
         r_prev        <= '0;
         r_seq_err     <= 1'b0;
         r_seq_err_cnt <= 8'd0;
      end else begin
         if (w_pop) begin
            r_prev      <= m_data;
            r_have_prev <= 1'b1;
         end
         if (w_mismatch) begin
            r_seq_err <= 1'b1;
            if (r_seq_err_cnt != 8'hFF) r_seq_err_cnt <= r_seq_err_cnt + 8'd1;
         end
      end
   end

   assign seq_err     = r_seq_err;
   assign seq_err_cnt = r_seq_err_cnt;
`else
   assign seq_err     = 1'b0;
   assign seq_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_asfifo_rd_drain.sv
// Directed bench for asfifo_rd_drain: queue-based FIFO model, in-order scoreboard,
// hand-computed latency, backpressure, reset and sequence-checker expectations.
module tb_asfifo_rd_drain;

   localparam int WIDTH = 16;
`ifdef ASFIFO_RD_SEQ_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             rd_clk = 1'b0;
   logic             rd_rst_n = 1'b0;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_rd_data = '0;
   logic             fifo_rd_empty = 1'b1;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [WIDTH-1:0] m_data;
   logic             seq_err;
   logic [7:0]       seq_err_cnt;

   asfifo_rd_drain #(.WIDTH(WIDTH)) dut (
      .rd_clk        (rd_clk),
      .rd_rst_n      (rd_rst_n),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_empty (fifo_rd_empty),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .seq_err       (seq_err),
      .seq_err_cnt   (seq_err_cnt)
   );

   always #5 rd_clk = ~rd_clk;

   int               errors = 0;
   int               checks = 0;
   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] sb[$];
   logic             pend_pop = 1'b0;
   logic             got_hs = 1'b0;
   int               hs_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs 1 time unit after the rising edge, observe on the falling edge.
   task automatic step(input logic rdy, input logic rst_v);
      @(posedge rd_clk);
      #1;
      rd_rst_n = rst_v;
      if (pend_pop) begin
         if (fq.size() == 0) begin
            check("pop_while_empty", 32'd1, 32'd0);
            fifo_rd_data = 16'hBAD0;
         end else begin
            fifo_rd_data = fq.pop_front();
            sb.push_back(fifo_rd_data);
         end
      end else begin
         fifo_rd_data = 16'hBAD0;
      end
      fifo_rd_empty = (fq.size() == 0);
      m_ready = rdy;
      @(negedge rd_clk);
      pend_pop = (fifo_rd_en === 1'b1);
      got_hs   = (m_valid === 1'b1) && m_ready;
      if (got_hs) begin
         hs_cnt++;
         if (sb.size() == 0) check("handshake_without_word", 32'd1, 32'd0);
         else check("m_data_order", 32'(m_data), 32'(sb.pop_front()));
      end
   endtask

   task automatic push_inc(input logic [WIDTH-1:0] first, input int n);
      logic [WIDTH-1:0] v;
      v = first;
      for (int i = 0; i < n; i++) begin
         fq.push_back(v);
         v = v + 16'd1;
      end
   endtask

   task automatic push_const(input logic [WIDTH-1:0] v, input int n);
      for (int i = 0; i < n; i++) fq.push_back(v);
   endtask

   task automatic drain(input string tag, input int n);
      int guard;
      hs_cnt = 0;
      guard  = 0;
      while ((hs_cnt < n || fq.size() != 0) && guard < 2 * n + 20) begin
         step(1'b1, 1'b1);
         guard++;
      end
      check(tag, 32'(hs_cnt), 32'(n));
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bubbles;
      int pops;
      int hold_bad;

      // Reset held with a non-empty FIFO: nothing may be popped.
      push_inc(16'h0000, 33);
      fifo_rd_empty = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_seq_err", 32'(seq_err), 32'd0);
      check("rst_seq_err_cnt", 32'(seq_err_cnt), 32'd0);
      check("rst_no_pops", 32'(fq.size()), 32'd33);

      // Streaming 0x0000..0x0020 with m_ready high.
      hs_cnt = 0;
      step(1'b1, 1'b1);
      check("stream_first_pop", 32'(fifo_rd_en), 32'd1);
      step(1'b1, 1'b1);
      check("stream_valid_n1", 32'(m_valid), 32'd0);
      bubbles = 0;
      for (int i = 0; i < 33; i++) begin
         step(1'b1, 1'b1);
         if (!got_hs) bubbles++;
      end
      check("stream_bubbles", 32'(bubbles), 32'd0);
      check("stream_handshakes", 32'(hs_cnt), 32'd33);
      step(1'b1, 1'b1);
      check("stream_drained_valid", 32'(m_valid), 32'd0);
      check("stream_seq_err", 32'(seq_err), 32'd0);

      // Backpressure: m_ready low for 10 cycles, then release.
      step(1'b0, 1'b1);
      push_inc(16'h0021, 8);
      pops = 0;
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1);
         if (pend_pop) pops++;
         if (i == 1) check("bp_valid_n1", 32'(m_valid), 32'd0);
         if (i == 2) check("bp_valid_n2", 32'(m_valid), 32'd1);
         if (i >= 2 && m_data !== 16'h0021) hold_bad++;
      end
      check("bp_pop_count", 32'(pops), 32'd3);
      check("bp_data_held", 32'(hold_bad), 32'd0);
      check("bp_rd_en_blocked", 32'(fifo_rd_en), 32'd0);
      drain("bp_release_count", 8);
      check("bp_no_extra", 32'(hs_cnt), 32'd8);
      check("bp_seq_err", 32'(seq_err), 32'd0);

      // Reset while occ=2 and one word is in flight.
      step(1'b0, 1'b1);
      push_inc(16'h0029, 4);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("mid_valid_before", 32'(m_valid), 32'd1);
      step(1'b0, 1'b0);
      check("mid_credit_full", 32'(fifo_rd_en), 32'd0);
      step(1'b0, 1'b0);
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_data", 32'(m_data), 32'd0);
      check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      fq.delete();
      sb.delete();
      pend_pop = 1'b0;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("mid_no_stale_word", 32'(m_valid), 32'd0);

      // Wrap-around of the incrementing pattern (also first handshake after reset).
      push_inc(16'hFFFE, 4);
      drain("wrap_count", 4);
      check("wrap_seq_err", 32'(seq_err), 32'd0);
      check("wrap_seq_err_cnt", 32'(seq_err_cnt), 32'd0);

      // Single sequence break: 0x0003 then 0x0005.
      fq.push_back(16'h0002);
      fq.push_back(16'h0003);
      fq.push_back(16'h0005);
      fq.push_back(16'h0006);
      drain("seq_count", 4);
      check("seq_err_flag", 32'(seq_err), CHK ? 32'd1 : 32'd0);
      check("seq_err_one", 32'(seq_err_cnt), CHK ? 32'd1 : 32'd0);

      // Counter saturation: 300 forced mismatches in total.
      push_const(16'h0000, 253);
      drain("sat_count_a", 253);
      check("sat_cnt_254", 32'(seq_err_cnt), CHK ? 32'd254 : 32'd0);
      push_const(16'h0000, 1);
      drain("sat_count_b", 1);
      check("sat_cnt_255", 32'(seq_err_cnt), CHK ? 32'd255 : 32'd0);
      push_const(16'h0000, 46);
      drain("sat_count_c", 46);
      check("sat_cnt_hold", 32'(seq_err_cnt), CHK ? 32'd255 : 32'd0);
      check("sat_seq_err", 32'(seq_err), CHK ? 32'd1 : 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/asfifo_rd_drain.md
# asfifo_rd_drain

Read-side drain engine for the `asfifo` block, living entirely in the read clock domain. It pops words from the FIFO read port whenever buffer credit allows and absorbs the FIFO's one-cycle read latency in a 3-entry holding buffer. It re-presents the words on a valid/ready stream so downstream logic never has to handle `rd_en`/`rd_empty` timing. An optional sequence checker verifies that the incrementing-pattern traffic used in FIFO bring-up arrives intact.

## Interface
Parameters:
- `WIDTH`, 16, data word width; must match the FIFO `WIDTH`.

Ports:
- `rd_clk`  in  1  read-domain clock; all logic on its rising edge.
- `rd_rst_n`  in  1  reset, synchronous, active-low.
- `fifo_rd_en`  out  1  pop request to FIFO `rd_en`.
- `fifo_rd_data`  in  WIDTH  FIFO `rd_data`; valid exactly one cycle after an accepted pop.
- `fifo_rd_empty`  in  1  FIFO `rd_empty`.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  downstream accepts when `m_valid && m_ready`.
- `m_data`  out  WIDTH  output word (buffer head).
- `seq_err`  out  1  sticky sequence-error flag.
- `seq_err_cnt`  out  8  saturating sequence-error count.

## Operation
- Pop rule: `fifo_rd_en = !fifo_rd_empty && (occ + inflight < 3)`; combinational from registered `occ`/`inflight` and `fifo_rd_empty` only. There is no path from `m_ready`.
- `inflight` (1 bit) is set on each cycle with `fifo_rd_en=1`. On the following cycle, `fifo_rd_data` is written into the buffer at `wptr`.
- Buffer: 3 entries of WIDTH bits, with 2-bit `wptr`/`rptr` wrapping 2→0, and `occ` in 0..3.
  - `occ` next = `occ + inflight − (m_valid && m_ready)`.
  - A write and a read in the same cycle are both performed, so `occ` is unchanged.
- Output: `m_valid = (occ != 0)` and `m_data = buf[rptr]`. Both are stable while `m_valid && !m_ready`.
- Overflow is impossible by the credit rule; `occ == 3` blocks popping.
- Underflow: `m_valid` stays low when `occ == 0`; `m_ready` is ignored.
- Sequence checker (macro-controlled):
  - Triggers on each output handshake after the first since reset.
  - Compares `m_data` with the previous handshaken word + 1, modulo 2^WIDTH, so 0xFFFF→0x0000 is legal.
  - On a mismatch: `seq_err` is set, and `seq_err_cnt` increments, saturating at 255.
  - The expected value always resynchronises to the received word.
- Reset mid-operation: buffer contents, any in-flight word, pointers and counters are discarded. The FIFO itself is reset by its own `rd_rst_n`.

## Timing
- Reset values: `fifo_rd_en=0` (occ/inflight cleared; follows `fifo_rd_empty` once `rd_rst_n` is high), `m_valid=0`, `m_data=0` (buffer cleared), `seq_err=0`, `seq_err_cnt=0`.
- Latency: `fifo_rd_empty` falls in cycle N → `fifo_rd_en=1` in N → data captured at the end of N+1 → `m_valid=1` in N+2.
- Throughput: 1 word/cycle sustained when `m_ready` is held high and the FIFO is non-empty. Steady state is `occ=1`, `inflight=1`.
- Backpressure: with `m_ready` low, at most 3 words are buffered and `fifo_rd_en` drops within 0 cycles of the credit being exhausted.
- Checker: `seq_err`/`seq_err_cnt` update in the cycle after the offending handshake.

## Configuration
- `ASFIFO_RD_SEQ_CHECK_EN` defined: the sequence checker, `seq_err` and `seq_err_cnt` are implemented as above.
- Not defined: no checker logic is built, and `seq_err`/`seq_err_cnt` are tied to 0. The ports remain present.

## Test plan
- Reset: hold `rd_rst_n=0` for 3 cycles with `fifo_rd_empty=0` → `fifo_rd_en=0`, `m_valid=0`, `m_data=0`, `seq_err_cnt=0`.
- Streaming: FIFO model supplies 0x0000..0x0020 with `m_ready=1` → `m_valid` rises 2 cycles after empty falls, then 33 consecutive handshakes with no bubbles. `seq_err=0`.
- Backpressure: `m_ready=0` for 10 cycles with a non-empty FIFO → exactly 3 pops, and `m_data` is held at the first word. Release → words delivered in order, none lost or duplicated.
- Wrap-around: data 0xFFFE, 0xFFFF, 0x0000, 0x0001 → no `seq_err` with the macro defined.
- Sequence error (macro on): inject 0x0005 after 0x0003, then 0x0006 → `seq_err=1`, `seq_err_cnt=1`. Force 300 mismatches → `seq_err_cnt=255`.
- Reset mid-stream: assert `rd_rst_n=0` while `occ=2` and `inflight=1` → next cycle `m_valid=0` and `occ=0`; the in-flight word is not captured.
